// File: rtl/sdram_req_bridge.sv
// Request bridge: queued writes and reads funnelled into a single-command SDRAM backend.
// Optional BRIDGE_DROP_CNT_EN adds drop_cnt[7:0], a saturating count of dropped requests.
module sdram_req_bridge #(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 16,
    parameter int WQ_DEPTH = 4,
    parameter int RQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] writeaddr,
    input  logic [DATA_W-1:0] writedata,
    output logic              wr_full,
    input  logic              read,
    input  logic [ADDR_W-1:0] readaddr,
    output logic              rd_busy,
    output logic [DATA_W-1:0] readdata,
    output logic              rd_empty,
    input  logic              rd_pop,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef BRIDGE_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    // state   | meaning
    // IDLE    | no command in flight, choosing next queue
    // WR_CMD  | presenting write-queue head to backend
    // RD_CMD  | presenting read-command head to backend
    // RD_WAIT | one read outstanding, waiting for mem_rvalid
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_CMD  = 2'd1,
        RD_CMD  = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    localparam int WQ_AW = $clog2(WQ_DEPTH);
    localparam int RQ_AW = $clog2(RQ_DEPTH);

    state_t state, state_nxt;

    logic [ADDR_W-1:0] wq_addr [WQ_DEPTH];
    logic [DATA_W-1:0] wq_data [WQ_DEPTH];
    logic [WQ_AW-1:0]  wq_wp, wq_rp;
    logic [WQ_AW:0]    wq_cnt;
    logic              wq_push, wq_pop;

    logic [ADDR_W-1:0] rq_addr [RQ_DEPTH];
    logic [RQ_AW-1:0]  rq_wp, rq_rp;
    logic [RQ_AW:0]    rq_cnt;
    logic              rq_push, rq_pop;

    logic [DATA_W-1:0] dq_data [RQ_DEPTH];
    logic [RQ_AW-1:0]  dq_wp, dq_rp;
    logic [RQ_AW:0]    dq_cnt;
    logic              dq_push, dq_pop;

    assign wr_full  = (wq_cnt == (WQ_AW+1)'(WQ_DEPTH));
    assign rd_busy  = (rq_cnt == (RQ_AW+1)'(RQ_DEPTH));
    assign rd_empty = (dq_cnt == '0);
    assign readdata = rd_empty ? '0 : dq_data[dq_rp];

    assign wq_push = write & ~wr_full;
    assign wq_pop  = (state == WR_CMD) & mem_ready;
    assign rq_push = read & ~rd_busy;
    assign rq_pop  = (state == RD_CMD) & mem_ready;
    assign dq_push = (state == RD_WAIT) & mem_rvalid;
    assign dq_pop  = rd_pop & ~rd_empty;

    // Storage arrays carry no reset; occupancy counters define validity.
    always_ff @(posedge clk) begin
        if (wq_push) begin
            wq_addr[wq_wp] <= writeaddr;
            wq_data[wq_wp] <= writedata;
        end
        if (rq_push)
            rq_addr[rq_wp] <= readaddr;
        if (dq_push)
            dq_data[dq_wp] <= mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wq_wp  <= '0;
            wq_rp  <= '0;
            wq_cnt <= '0;
        end else begin
            if (wq_push)
                wq_wp <= wq_wp + WQ_AW'(1);
            if (wq_pop)
                wq_rp <= wq_rp + WQ_AW'(1);
            case ({wq_push, wq_pop})
                2'b10:   wq_cnt <= wq_cnt + (WQ_AW+1)'(1);
                2'b01:   wq_cnt <= wq_cnt - (WQ_AW+1)'(1);
                default: wq_cnt <= wq_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rq_wp  <= '0;
            rq_rp  <= '0;
            rq_cnt <= '0;
        end else begin
            if (rq_push)
                rq_wp <= rq_wp + RQ_AW'(1);
            if (rq_pop)
                rq_rp <= rq_rp + RQ_AW'(1);
            case ({rq_push, rq_pop})
                2'b10:   rq_cnt <= rq_cnt + (RQ_AW+1)'(1);
                2'b01:   rq_cnt <= rq_cnt - (RQ_AW+1)'(1);
                default: rq_cnt <= rq_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dq_wp  <= '0;
            dq_rp  <= '0;
            dq_cnt <= '0;
        end else begin
            if (dq_push)
                dq_wp <= dq_wp + RQ_AW'(1);
            if (dq_pop)
                dq_rp <= dq_rp + RQ_AW'(1);
            case ({dq_push, dq_pop})
                2'b10:   dq_cnt <= dq_cnt + (RQ_AW+1)'(1);
                2'b01:   dq_cnt <= dq_cnt - (RQ_AW+1)'(1);
                default: dq_cnt <= dq_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A read is only issued when its data is guaranteed a slot in the data queue.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (wq_cnt != '0)
                    state_nxt = WR_CMD;
                else if ((rq_cnt != '0) && (dq_cnt < (RQ_AW+1)'(RQ_DEPTH)))
                    state_nxt = RD_CMD;
            end
            WR_CMD: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wq_addr[wq_rp];
                mem_wdata = wq_data[wq_rp];
                if (mem_ready)
                    state_nxt = IDLE;
            end
            RD_CMD: begin
                mem_req  = 1'b1;
                mem_addr = rq_addr[rq_rp];
                if (mem_ready)
                    state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rvalid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef BRIDGE_DROP_CNT_EN
    logic [1:0] drop_inc;
    logic [8:0] drop_sum;

    assign drop_inc = {1'b0, write & wr_full} + {1'b0, read & rd_busy};
    assign drop_sum = {1'b0, drop_cnt} + {7'b0, drop_inc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_cnt <= '0;
        else
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
`endif

endmodule

// File: tb/tb_sdram_req_bridge.sv
// Randomized bench for sdram_req_bridge: queue-level reference model plus a simple backend memory.
module tb_sdram_req_bridge;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int D  = 4;

    logic          clk, reset;
    logic          write, read, rd_pop;
    logic [AW-1:0] writeaddr, readaddr;
    logic [DW-1:0] writedata;
    logic          wr_full, rd_busy, rd_empty;
    logic [DW-1:0] readdata;
    logic          mem_req, mem_we, mem_ready, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef BRIDGE_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    sdram_req_bridge #(.ADDR_W(AW), .DATA_W(DW), .WQ_DEPTH(D), .RQ_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .write(write), .writeaddr(writeaddr), .writedata(writedata), .wr_full(wr_full),
        .read(read), .readaddr(readaddr), .rd_busy(rd_busy),
        .readdata(readdata), .rd_empty(rd_empty), .rd_pop(rd_pop),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef BRIDGE_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct packed { logic [AW-1:0] a; logic [31:0] need; } rd_t;

    wr_t           wq_m[$];
    rd_t           rq_m[$];
    logic [DW-1:0] dq_m[$];
    logic [DW-1:0] bmem [8];
    bit            outst;
    logic [DW-1:0] pend;
    int            wr_enq, wr_iss, drop_m;
    int            n_tests, n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        wq_m.delete();
        rq_m.delete();
        dq_m.delete();
        outst  = 1'b0;
        wr_enq = 0;
        wr_iss = 0;
        drop_m = 0;
    endtask

    task automatic check_outputs();
        chk("wr_full", 32'(wr_full), 32'(wq_m.size() == D));
        chk("rd_busy", 32'(rd_busy), 32'(rq_m.size() == D));
        chk("rd_empty", 32'(rd_empty), 32'(dq_m.size() == 0));
        if (dq_m.size() > 0)
            chk("readdata", 32'(readdata), 32'(dq_m[0]));
        if (!mem_req) begin
            chk("idle_we", 32'(mem_we), 0);
            chk("idle_wdata", 32'(mem_wdata), 0);
        end else if (mem_we) begin
            chk("wr_cmd_q", 32'(wq_m.size() != 0), 1);
            if (wq_m.size() != 0) begin
                chk("wr_addr", 32'(mem_addr), 32'(wq_m[0].a));
                chk("wr_data", 32'(mem_wdata), 32'(wq_m[0].d));
            end
        end else begin
            chk("rd_cmd_q", 32'(rq_m.size() != 0), 1);
            chk("rd_one_outst", 32'(outst), 0);
            chk("rd_gate", 32'(dq_m.size() < D), 1);
            if (rq_m.size() != 0) begin
                chk("rd_addr", 32'(mem_addr), 32'(rq_m[0].a));
                chk("rd_after_wr", 32'(wr_iss >= int'(rq_m[0].need)), 1);
            end
        end
`ifdef BRIDGE_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(drop_m));
`endif
    endtask

    // One clock: check, drive random inputs, then advance the model across the coming edge.
    task automatic cycle(input int pw, input int pr, input int prdy, input int ppop);
        bit wfull, rbusy, rv_used;
        int dsz, drops;
        @(negedge clk);
        check_outputs();
        write     = ($urandom_range(99) < pw);
        writeaddr = AW'($urandom_range(7));
        writedata = DW'($urandom);
        read      = ($urandom_range(99) < pr);
        readaddr  = AW'($urandom_range(7));
        rd_pop    = ($urandom_range(99) < ppop);
        mem_ready = ($urandom_range(99) < prdy);
        mem_rdata = DW'($urandom);
        if (outst) begin
            mem_rvalid = ($urandom_range(99) < 50);
            if (mem_rvalid) mem_rdata = pend;
        end else begin
            mem_rvalid = ($urandom_range(99) < 10);
        end

        wfull = (wq_m.size() == D);
        rbusy = (rq_m.size() == D);
        dsz   = dq_m.size();
        drops = int'(write && wfull) + int'(read && rbusy);
        drop_m = (drop_m + drops > 255) ? 255 : drop_m + drops;

        if (rd_pop && dsz > 0) void'(dq_m.pop_front());
        rv_used = outst && mem_rvalid;
        if (rv_used) begin
            dq_m.push_back(pend);
            outst = 1'b0;
        end
        if (mem_req && mem_ready) begin
            if (mem_we && wq_m.size() > 0) begin
                bmem[wq_m[0].a[2:0]] = wq_m[0].d;
                void'(wq_m.pop_front());
                wr_iss++;
            end else if (!mem_we && rq_m.size() > 0) begin
                pend  = bmem[rq_m[0].a[2:0]];
                outst = 1'b1;
                void'(rq_m.pop_front());
            end
        end
        if (read && !rbusy) rq_m.push_back('{a: readaddr, need: 32'(wr_enq)});
        if (write && !wfull) begin
            wq_m.push_back('{a: writeaddr, d: writedata});
            wr_enq++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_readdata"}, 32'(readdata), 0);
        chk({tag, "_wr_full"}, 32'(wr_full), 0);
        chk({tag, "_rd_busy"}, 32'(rd_busy), 0);
        chk({tag, "_rd_empty"}, 32'(rd_empty), 1);
`ifdef BRIDGE_DROP_CNT_EN
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
`endif
    endtask

    initial begin
        int k;
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 8; i++) bmem[i] = DW'(16'h1000 + i);
        reset = 1'b1;
        write = 0; read = 0; rd_pop = 0; mem_ready = 0; mem_rvalid = 0;
        writeaddr = '0; writedata = '0; readaddr = '0; mem_rdata = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;

        repeat (8)    cycle(100, 0, 0, 0);      // fill write queue with backend stalled
        repeat (12)   cycle(0, 0, 100, 0);
        repeat (40)   cycle(0, 100, 100, 0);    // fill read-data queue, no pops
        repeat (20)   cycle(0, 0, 100, 100);
        repeat (2000) cycle(40, 40, 70, 40);
        repeat (300)  cycle(90, 90, 30, 20);

        k = 0;
        while (!outst && k < 300) begin
            cycle(0, 80, 100, 50);
            k++;
        end
        chk("reach_rd_wait", 32'(outst), 1);
        @(negedge clk);
        reset = 1'b1;
        write = 0; read = 0; rd_pop = 0; mem_ready = 0; mem_rvalid = 0;
        @(negedge clk);
        check_reset_state("mid_rst");
        reset = 1'b0;
        model_clear();
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("late_rvalid_empty", 32'(rd_empty), 1);
        chk("late_rvalid_req", 32'(mem_req), 0);

        repeat (500) cycle(50, 50, 60, 50);
        repeat (80)  cycle(0, 0, 100, 100);
        chk("drain_wq", 32'(wq_m.size()), 0);
        chk("drain_rq", 32'(rq_m.size()), 0);
        chk("drain_outst", 32'(outst), 0);
        chk("drain_wr_count", 32'(wr_iss), 32'(wr_enq));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
